// File: rtl/oam_dma_pkg.sv
// OAM DMA shared definitions: controller state encoding, M-cycle phase
// constants and the default trigger address, OAM base and transfer length.
package oam_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    XFER = 2'd2
  } dma_state_t;

  // Phases of one CPU M-cycle as seen by the phase counter.
  localparam logic [1:0] CT_ADDR  = 2'd0;  // address setup
  localparam logic [1:0] CT_HOLD  = 2'd1;  // read strobe held
  localparam logic [1:0] CT_LATCH = 2'd2;  // data latch / trigger sample
  localparam logic [1:0] CT_IDLE  = 2'd3;  // idle, OAM write slot

  localparam int unsigned DMA_LEN_DEF  = 160;
  localparam logic [15:0] DMA_REG_DEF  = 16'hFF46;
  localparam logic [15:0] OAM_BASE_DEF = 16'hFE00;

endpackage

// File: rtl/oam_dma_if.sv
// OAM DMA signal bundle: CPU side request/response, system bus and OAM
// write port. The slave modport is the DMA controller's view; the master
// modport is the view of whatever drives the CPU side and the bus memory.
interface oam_dma_if;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [15:0] a;
  logic [7:0]  dout;
  logic [7:0]  din;
  logic        rd;
  logic        wr;
  logic [7:0]  oam_a;
  logic [7:0]  oam_dout;
  logic        oam_we;
  logic        dma_active;

  modport slave (
    input  cpu_a, cpu_dout, cpu_rd, cpu_wr, din,
    output cpu_din, a, dout, rd, wr, oam_a, oam_dout, oam_we, dma_active
  );

  modport master (
    output cpu_a, cpu_dout, cpu_rd, cpu_wr, din,
    input  cpu_din, a, dout, rd, wr, oam_a, oam_dout, oam_we, dma_active
  );
endinterface

// File: rtl/oam_dma_phase.sv
// dma_phase: free-running 2-bit M-cycle phase counter (0..3, wraps 3->0).
// Ports: clk, rst (async, active-high, forces ct=0), ct (current phase).
module dma_phase
  import oam_dma_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] ct
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ct <= CT_ADDR;
    else     ct <= ct + 2'd1;
  end

endmodule

// File: rtl/oam_dma.sv
// oam_dma: sprite-attribute DMA. A CPU write to DMA_REG at phase 2 latches a
// source page; the controller then copies DMA_LEN bytes from {src,idx} on the
// system bus into OAM, one byte per 4-clock M-cycle, while arbitrating CPU
// access (only FF00-FFFF reachable while active).
// Ports: clk, rst (async, active-high); bus (oam_dma_if.slave) carrying the
// CPU side (cpu_a/cpu_dout/cpu_din/cpu_rd/cpu_wr), system bus
// (a/dout/din/rd/wr), OAM port (oam_a/oam_dout/oam_we) and dma_active.
// Build option: define OAM_DMA_READBACK_EN to make CPU reads of DMA_REG return
// the latched source page instead of going to the bus.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter int unsigned DMA_LEN  = DMA_LEN_DEF,
  parameter logic [15:0] DMA_REG  = DMA_REG_DEF,
  parameter logic [15:0] OAM_BASE = OAM_BASE_DEF
) (
  input logic        clk,
  input logic        rst,
  oam_dma_if.slave   bus
);

  logic [1:0] ct;
  dma_state_t state, state_nxt;
  logic [7:0] src;
  logic [7:0] idx;
  logic [7:0] byte_q;
  logic       trigger;
  logic       last;
  logic       xfer_bus;
  logic       hi_page;

  dma_phase u_phase (
    .clk (clk),
    .rst (rst),
    .ct  (ct)
  );

  assign trigger  = bus.cpu_wr && (bus.cpu_a == DMA_REG) && (ct == CT_LATCH);
  assign last     = (idx == 8'(DMA_LEN - 1));
  assign xfer_bus = (state == XFER) && (ct != CT_IDLE);
  assign hi_page  = (bus.cpu_a[15:8] == 8'hFF);

  // A trigger wins in every state, so a retrigger restarts from ARM.
  always_comb begin
    state_nxt = state;
    if (trigger) begin
      state_nxt = ARM;
    end else begin
      unique case (state)
        IDLE:    state_nxt = IDLE;
        ARM:     if (ct == CT_IDLE) state_nxt = XFER;
        XFER:    if (ct == CT_IDLE && last) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      src    <= '0;
      idx    <= '0;
      byte_q <= '0;
    end else begin
      state <= state_nxt;
      if (trigger) begin
        src <= bus.cpu_dout;
        idx <= '0;
      end else if (state == XFER && ct == CT_IDLE) begin
        idx <= last ? '0 : idx + 8'd1;
      end
      if (state == XFER && ct == CT_LATCH) byte_q <= bus.din;
    end
  end

  // Bus arbitration. Reset is folded in combinationally because the CPU-side
  // passthrough would otherwise leak straight onto the bus during reset.
  always_comb begin
    bus.a       = bus.cpu_a;
    bus.dout    = bus.cpu_dout;
    bus.rd      = bus.cpu_rd;
    bus.wr      = bus.cpu_wr;
    bus.cpu_din = bus.din;
`ifdef OAM_DMA_READBACK_EN
    if (bus.cpu_rd && bus.cpu_a == DMA_REG) bus.cpu_din = src;
`endif
    if (rst) begin
      bus.a       = '0;
      bus.dout    = '0;
      bus.rd      = 1'b0;
      bus.wr      = 1'b0;
      bus.cpu_din = bus.din;
    end else if (xfer_bus) begin
      bus.a       = {src, idx};
      bus.dout    = '0;
      bus.rd      = (ct == CT_ADDR) || (ct == CT_HOLD);
      bus.wr      = 1'b0;
      bus.cpu_din = 8'hFF;
    end else if (state != IDLE && !hi_page) begin
      bus.rd      = 1'b0;
      bus.wr      = 1'b0;
      bus.cpu_din = 8'hFF;
    end
  end

  // OAM index is relative to the OAM page; the standard base adds nothing.
  assign bus.oam_a      = idx + OAM_BASE[7:0];
  assign bus.oam_dout   = byte_q;
  assign bus.oam_we     = (state == XFER) && (ct == CT_IDLE);
  assign bus.dma_active = (state != IDLE);

endmodule

// File: tb/tb_oam_dma.sv
// Testbench for oam_dma: randomized triggers against a transaction-level
// reference model. Stimulus tasks push expected bus reads and OAM writes
// (with their cycle numbers) into queues; a monitor pops and compares them.
module tb_oam_dma;

  localparam int LEN = 160;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   edges  = 0;

  exp_t wq[$];
  exp_t rq[$];
  int   m_lo = 0;
  int   m_hi = -1;

  oam_dma_if bus();

  oam_dma #(
    .DMA_LEN  (160),
    .DMA_REG  (16'hFF46),
    .OAM_BASE (16'hFE00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_f(input logic [15:0] ad);
    logic [7:0] t;
    t = ad[7:0] * 8'd7;
    t = t + ad[15:8];
    return t ^ 8'h3C;
  endfunction

  assign bus.din = mem_f(bus.a);

  // Clocks since reset release; phase = edges % 4.
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queues.
  always @(negedge clk) begin
    int   c;
    exp_t e;
    c = edges;
    while (wq.size() > 0 && wq[0].cyc < c) begin
      e = wq.pop_front();
      checks++; errors++;
      $display("FAIL oam_write_missing: got none expected idx %0h at cycle %0d", e.addr[7:0], e.cyc);
    end
    while (rq.size() > 0 && rq[0].cyc < c) begin
      e = rq.pop_front();
      checks++; errors++;
      $display("FAIL dma_read_missing: got none expected addr %0h at cycle %0d", e.addr, e.cyc);
    end
    if (bus.oam_we) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL oam_write_unexpected: got oam_a %0h expected no write (cycle %0d)", bus.oam_a, c);
      end else begin
        e = wq.pop_front();
        chk("oam_write_cycle", c, e.cyc);
        chk("oam_a", bus.oam_a, e.addr[7:0]);
        chk("oam_dout", bus.oam_dout, e.data);
      end
    end
    if ((c % 4) == 0 && bus.rd && bus.dma_active) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL dma_read_unexpected: got addr %0h expected no read (cycle %0d)", bus.a, c);
      end else begin
        e = rq.pop_front();
        chk("dma_read_cycle", c, e.cyc);
        chk("dma_read_addr", bus.a, e.addr);
      end
    end
    chk("dma_active", bus.dma_active, (c >= m_lo && c <= m_hi));
  end

  task automatic idle_bus();
    bus.cpu_a = '0; bus.cpu_dout = '0; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
  endtask

  task automatic at_phase(input int p);
    int n;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while ((edges % 4) != p && n < 8);
  endtask

  task automatic wait_until(input int target);
    int n;
    n = 0;
    while (edges < target && n < 2000) begin
      @(posedge clk); #2;
      n++;
    end
    if (edges < target) chk("wait_until_timeout", edges, target);
  endtask

  task automatic trigger(input logic [7:0] s, output int tc);
    exp_t e;
    at_phase(2);
    bus.cpu_a = 16'hFF46; bus.cpu_dout = s; bus.cpu_wr = 1'b1; bus.cpu_rd = 1'b0;
    tc = edges;
    if (!(tc >= m_lo && tc <= m_hi)) m_lo = tc + 1;
    m_hi = tc + 5 + 4 * (LEN - 1);
    wq.delete();
    rq.delete();
    for (int i = 0; i < LEN; i++) begin
      e.cyc  = tc + 2 + 4 * i;
      e.addr = {s, 8'(i)};
      e.data = '0;
      rq.push_back(e);
      e.cyc  = tc + 5 + 4 * i;
      e.data = mem_f({s, 8'(i)});
      wq.push_back(e);
    end
    @(posedge clk); #2;
    idle_bus();
  endtask

  task automatic wait_level(input logic lvl, input int limit, output int at);
    bit seen;
    seen = 1'b0;
    at = -1;
    for (int i = 0; i < limit && !seen; i++) begin
      @(posedge clk); #2;
      if (bus.dma_active == lvl) begin
        seen = 1'b1;
        at = edges;
      end
    end
    if (!seen) chk("dma_active_wait_timeout", bus.dma_active, lvl);
  endtask

  logic [7:0] rb_exp;
  int tc, tc2, ic, ac;
  logic [7:0] srcs[4];
  logic [15:0] ra;
  logic [7:0]  rd8;

  initial begin
    idle_bus();
    bus.cpu_a = 16'h1234; bus.cpu_dout = 8'h77; bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b1;
    @(posedge clk); #2;
    chk("rst_a", bus.a, 16'h0);
    chk("rst_dout", bus.dout, 8'h0);
    chk("rst_rd", bus.rd, 1'b0);
    chk("rst_wr", bus.wr, 1'b0);
    chk("rst_oam_a", bus.oam_a, 8'h0);
    chk("rst_oam_dout", bus.oam_dout, 8'h0);
    chk("rst_oam_we", bus.oam_we, 1'b0);
    chk("rst_dma_active", bus.dma_active, 1'b0);
    chk("rst_cpu_din", bus.cpu_din, mem_f(16'h0));
    @(posedge clk); #2;
    rst = 1'b0;
    idle_bus();

    // Idle passthrough with random CPU traffic (never the trigger register).
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      ra = 16'($urandom);
      if (ra == 16'hFF46) ra = 16'hFF45;
      rd8 = 8'($urandom);
      bus.cpu_a = ra; bus.cpu_dout = rd8;
      bus.cpu_rd = 1'($urandom); bus.cpu_wr = 1'($urandom);
      #2;
      chk("idle_a", bus.a, ra);
      chk("idle_dout", bus.dout, rd8);
      chk("idle_rd", bus.rd, bus.cpu_rd);
      chk("idle_wr", bus.wr, bus.cpu_wr);
      chk("idle_cpu_din", bus.cpu_din, mem_f(ra));
    end
    idle_bus();

    // Full C1 transfer with CPU arbitration and readback probes.
    trigger(8'hC1, tc);
    wait_until(tc + 2 + 4 * 10);
    bus.cpu_rd = 1'b1; bus.cpu_a = 16'hC000; #1;
    chk("xfer_ct0_cpu_din", bus.cpu_din, 8'hFF);
    chk("xfer_ct0_a", bus.a, 16'hC10A);
    at_phase(3);
    bus.cpu_rd = 1'b1; bus.cpu_a = 16'hC000; #1;
    chk("blocked_read_cpu_din", bus.cpu_din, 8'hFF);
    chk("blocked_read_rd", bus.rd, 1'b0);
    at_phase(3);
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b1; bus.cpu_a = 16'hFF80; bus.cpu_dout = 8'h5A; #1;
    chk("hram_write_a", bus.a, 16'hFF80);
    chk("hram_write_wr", bus.wr, 1'b1);
    chk("hram_write_dout", bus.dout, 8'h5A);
    at_phase(3);
    bus.cpu_wr = 1'b1; bus.cpu_a = 16'hC000; #1;
    chk("blocked_write_wr", bus.wr, 1'b0);
    at_phase(3);
    bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b1; bus.cpu_a = 16'hFF46; #1;
`ifdef OAM_DMA_READBACK_EN
    rb_exp = 8'hC1;
`else
    rb_exp = mem_f(16'hFF46);
`endif
    chk("readback_active", bus.cpu_din, rb_exp);
    @(posedge clk); #2;
    idle_bus();
    wait_level(1'b0, 700, ic);
    at_phase(1);
    bus.cpu_rd = 1'b1; bus.cpu_a = 16'hFF46; #1;
    chk("readback_idle", bus.cpu_din, rb_exp);
    idle_bus();

    // Retrigger with D0 while byte 40 is in flight.
    trigger(8'h20, tc);
    wait_until(tc + 2 + 4 * 40);
    trigger(8'hD0, tc2);
    wait_until(tc2 + 2);
    chk("retrig_first_read_a", bus.a, 16'hD000);
    chk("retrig_first_read_rd", bus.rd, 1'b1);
    wait_level(1'b0, 700, ic);

    // Random pages, including FE/FF, one with a random retrigger.
    srcs[0] = 8'hFE; srcs[1] = 8'hFF; srcs[2] = 8'($urandom); srcs[3] = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
      trigger(srcs[k], tc);
      if (k == 3) begin
        wait_until(tc + 2 + 4 * $urandom_range(1, 150));
        trigger(8'($urandom), tc2);
      end
      wait_level(1'b0, 700, ic);
    end

    // Reset in the middle of byte 80.
    trigger(8'($urandom), tc);
    wait_until(tc + 3 + 4 * 80);
    bus.cpu_a = 16'hABCD; bus.cpu_dout = 8'h99; bus.cpu_wr = 1'b1; bus.cpu_rd = 1'b1;
    rst = 1'b1;
    wq.delete(); rq.delete();
    m_lo = 0; m_hi = -1;
    #1;
    chk("midrst_a", bus.a, 16'h0);
    chk("midrst_dout", bus.dout, 8'h0);
    chk("midrst_rd", bus.rd, 1'b0);
    chk("midrst_wr", bus.wr, 1'b0);
    chk("midrst_oam_a", bus.oam_a, 8'h0);
    chk("midrst_oam_dout", bus.oam_dout, 8'h0);
    chk("midrst_oam_we", bus.oam_we, 1'b0);
    chk("midrst_dma_active", bus.dma_active, 1'b0);
    chk("midrst_cpu_din", bus.cpu_din, mem_f(16'h0));
    repeat (3) @(posedge clk);
    #2;
    idle_bus();
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #2;

    // Back-to-back transfers must leave at least one idle M-cycle between.
    trigger(8'h80, tc);
    wait_level(1'b0, 700, ic);
    trigger(8'h81, tc2);
    wait_level(1'b1, 20, ac);
    chk("idle_gap_ge_4", (ac - ic) >= 4, 1'b1);
    wait_level(1'b0, 700, ic);

    repeat (8) @(posedge clk);
    #2;
    chk("pending_writes", wq.size(), 0);
    chk("pending_reads", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DMA_LEN, 160, bytes per transfer.
- DMA_REG, 16'hFF46, trigger register address.
- OAM_BASE, 16'hFE00, destination base.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock.
- rst, in, 1, reset; asynchronous, active-high.
- cpu_a, in, 16, CPU address.
- cpu_dout, in, 8, CPU write data.
- cpu_din, out, 8, read data returned to CPU.
- cpu_rd, in, 1, CPU read strobe.
- cpu_wr, in, 1, CPU write strobe.
- a, out, 16, system bus address.
- dout, out, 8, system bus write data.
- din, in, 8, system bus read data.
- rd, out, 1, system bus read strobe.
- wr, out, 1, system bus write strobe.
- oam_a, out, 8, OAM byte index.
- oam_dout, out, 8, OAM write data.
- oam_we, out, 1, OAM write enable.
- dma_active, out, 1, DMA owns the bus.

Function
REQ-003 Internal 2-bit phase counter ct SHALL free-run 0..3 from reset, wrapping 3->0, aligned with the CPU M-cycle: ct=0 is address setup, ct=2 is data latch, ct=3 is idle.
REQ-004 A trigger is cpu_wr=1 with cpu_a==DMA_REG at ct=2; it SHALL latch src=cpu_dout into an 8-bit source-page register.
REQ-005 States: IDLE, ARM, XFER. IDLE->ARM on trigger. ARM->XFER at the next ct 3->0 boundary. XFER->IDLE after the byte with idx==DMA_LEN-1 completes at ct=3.
REQ-006 XFER, per M-cycle with index idx (8-bit, starts at 0):
- ct=0: a={src,idx}, rd=1.
- ct=2: latch din; rd=0.
- ct=3: oam_we=1, oam_a=idx, oam_dout=latched byte; then idx increments.
REQ-007 Latency SHALL be exactly 4 clocks per byte; for a trigger at ct=2 of M-cycle n, the first read occurs at ct=0 of M-cycle n+1 and the last OAM write at ct=3 of M-cycle n+DMA_LEN.
REQ-008 dma_active SHALL be 1 in ARM and XFER and 0 in IDLE.
REQ-009 While dma_active=0, a/dout/rd/wr SHALL pass cpu_a/cpu_dout/cpu_rd/cpu_wr through unchanged, and cpu_din SHALL equal din.
REQ-010 While dma_active=1:
- CPU accesses with cpu_a in FF00-FFFF SHALL pass through.
- CPU accesses elsewhere SHALL be blocked: writes dropped, wr=0, cpu_din=8'hFF.
- In XFER at ct=0..2 the DMA address SHALL take priority and the CPU sees 8'hFF.
REQ-011 A retrigger while ARM or XFER SHALL relatch src, reset idx to 0, enter ARM, and keep dma_active=1 throughout.
REQ-012 src values FE/FF SHALL be used as given (reads from {src,idx}, no remapping).
REQ-013 idx SHALL never exceed DMA_LEN-1; oam_we SHALL be 0 outside XFER ct=3.

Reset
REQ-014 On rst, the following SHALL be forced immediately and asynchronously:
- state=IDLE, ct=0, idx=0, src=0.
- a=0, dout=0, rd=0, wr=0, oam_a=0, oam_dout=0, oam_we=0, dma_active=0.
- cpu_din=din (passthrough).
REQ-015 Reset asserted mid-transfer SHALL abort the transfer with no further oam_we pulses.

Configuration
REQ-016 With OAM_DMA_READBACK_EN defined, a CPU read of DMA_REG SHALL return the latched src. Without it, the read SHALL pass to the bus as an ordinary IO read.

Structure
REQ-017 A shared package SHALL hold the state enum (IDLE/ARM/XFER), the ct phase constants, and the DMA_REG/OAM_BASE/DMA_LEN defaults.
REQ-018 The phase counter SHALL be a sub-module, dma_phase, outputting ct; the rest stays flat.

Verification
REQ-019 Write 8'hC1 to FF46 at ct=2 -> 160 reads at C100..C19F, one per 4 clocks; oam_we pulses with oam_a 0..159 and data matching the C1xx pattern; dma_active falls after oam_a=159.
REQ-020 During XFER, CPU read of C000 -> cpu_din=8'hFF; CPU write to FF80=8'h5A -> bus write passes (a=FF80, wr=1).
REQ-021 Retrigger with 8'hD0 at idx=40 -> the next read is D000, oam_a restarts at 0, dma_active stays 1.
REQ-022 Assert rst at idx=80 -> all outputs return to reset values the same cycle, with no oam_we afterwards.
REQ-023 Read FF46 after triggering 8'hC1 -> returns C1 with OAM_DMA_READBACK_EN defined; returns bus din without it.
REQ-024 Back-to-back: trigger 8'h80, wait for completion, trigger 8'h81 -> two complete transfers with dma_active=0 for at least one M-cycle between them.
